// File: rtl/fpu_issue_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_issue_sched: in-order dual-capture queue issuing to the shared FPU     |
// | under an outstanding-op credit limit, with serialising-op drain/wait.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fpu_issue_sched #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  logic                     in_fpu0,
  input  logic                     in_fpu1,
  input  logic                     in_serial0,
  input  logic                     in_serial1,
  input  logic [31:0]              in_inst0,
  input  logic [31:0]              in_inst1,
  input  logic [TAG_W-1:0]         in_tag0,
  input  logic [TAG_W-1:0]         in_tag1,
  output logic                     take0,
  output logic                     take1,
  output logic                     fpu_fetched,
  output logic                     sched_busy,
  output logic                     fpu_req_valid,
  output logic [31:0]              fpu_req_inst,
  output logic [TAG_W-1:0]         fpu_req_tag,
  input  logic                     fpu_req_ready,
  input  logic                     fpu_done,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  logic [31:0]      r_inst [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [DEPTH-1:0] r_serial;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [OW-1:0]    r_outst;
  state_t           r_state;
  state_t           w_state_next;

  logic             w_sel0;
  logic             w_sel1;
  logic [1:0]       w_need;
  logic [AW:0]      w_free;
  logic             w_cap;
  logic             w_empty;
  logic             w_head_serial;
  logic             w_room;
  logic             w_gate;
  logic             w_fire;
  logic             w_done_eff;
  logic [AW-1:0]    w_wr1;

  assign w_sel0  = in_valid0 & in_fpu0;
  assign w_sel1  = in_valid1 & in_fpu1;
  assign w_need  = {1'b0, w_sel0} + {1'b0, w_sel1};
  assign w_free  = (AW+1)'(DEPTH) - r_count;
  // A pair is captured whole or not at all; free space ignores this cycle's pop.
  assign w_cap   = (w_need != 2'd0) & ((AW+1)'(w_need) <= w_free) & ~flush;

  assign take0       = w_cap & w_sel0;
  assign take1       = w_cap & w_sel1;
  assign fpu_fetched = take0 | take1;
  assign sched_busy  = (w_need != 2'd0) & ~w_cap & ~flush;

  assign w_empty       = (r_count == '0);
  assign w_head_serial = r_serial[r_rd_ptr];
  assign w_room        = (r_outst < OW'(MAX_OUTST));
  assign w_done_eff    = fpu_done & (r_outst != '0);

  always_comb begin
    w_gate       = 1'b0;
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (!w_head_serial || r_outst == '0) begin
          w_gate = 1'b1;
        end else if (!w_empty) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_outst == '0) begin
          w_gate       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_WAIT_DONE: begin
        if (r_outst == '0) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
    if (w_fire && w_head_serial) begin
      w_state_next = ST_WAIT_DONE;
    end
    if (flush) begin
      w_state_next = ST_RUN;
    end
  end

  assign fpu_req_valid = ~w_empty & ~flush & w_room & w_gate;
  assign w_fire        = fpu_req_valid & fpu_req_ready;
  assign fpu_req_inst  = r_inst[r_rd_ptr];
  assign fpu_req_tag   = r_tag[r_rd_ptr];
  assign q_count       = r_count;

  // Slot0 lands first; slot1 follows it, or takes the write pointer when alone.
  assign w_wr1 = r_wr_ptr + AW'(take0);

  always_ff @(posedge clk) begin
    if (take0) begin
      r_inst[r_wr_ptr]   <= in_inst0;
      r_tag[r_wr_ptr]    <= in_tag0;
      r_serial[r_wr_ptr] <= in_serial0;
    end
    if (take1) begin
      r_inst[w_wr1]   <= in_inst1;
      r_tag[w_wr1]    <= in_tag1;
      r_serial[w_wr1] <= in_serial1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(take0) + AW'(take1);
      r_rd_ptr <= r_rd_ptr + AW'(w_fire);
      r_count  <= r_count + (AW+1)'(take0) + (AW+1)'(take1) - (AW+1)'(w_fire);
      r_outst  <= r_outst + OW'(w_fire) - OW'(w_done_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

endmodule
`default_nettype wire
